// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
package bcd_sched_pkg;

  localparam int unsigned BCD_ITER = 8;
  localparam int unsigned BIN_W    = 8;
  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned SR_W     = 3 * DIGIT_W + BIN_W;

  // {hundreds, tens, ones, bin}
  typedef logic [SR_W-1:0] bcd_sr_t;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    RESPOND
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to each BCD digit >= 5, then shift left by one.
module bcd_dabble_step
  import bcd_sched_pkg::*;
(
  input  logic [SR_W-1:0] word_in,
  output logic [SR_W-1:0] word_out
);

  logic [SR_W-1:0] adj;

  // Correct each digit that would overflow on doubling, then shift the whole word.
  always_comb begin
    adj = word_in;
    for (int unsigned d = 0; d < 3; d++) begin
      if (word_in[BIN_W + d*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5)) begin
        adj[BIN_W + d*DIGIT_W +: DIGIT_W] = word_in[BIN_W + d*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
      end
    end
    word_out = adj << 1;
  end

endmodule

// File: rtl/bcd_convert_scheduler.sv
// Arbitrates NUM_REQ requesters and converts the granted 8-bit value to three BCD digits.
// Optional feature: define BCD_SCHED_RR_EN for round-robin grant (default fixed priority, lowest index wins).
module bcd_convert_scheduler
  import bcd_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [8*NUM_REQ-1:0]     req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IDW-1:0]           rsp_id,
  output logic [DIGIT_W-1:0]       rsp_hundreds,
  output logic [DIGIT_W-1:0]       rsp_tens,
  output logic [DIGIT_W-1:0]       rsp_ones,
  output logic                     busy
);

  localparam int unsigned CNT_W = $clog2(BCD_ITER + 1);

  state_t          state_q;
  state_t          state_d;
  logic [CNT_W-1:0] cnt_q;
  bcd_sr_t         sr_q;
  bcd_sr_t         sr_step;
  logic [IDW-1:0]  id_q;
  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic            accept;

`ifdef BCD_SCHED_RR_EN
  logic [IDW-1:0] ptr_q;

  // Round-robin search starting at the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[(32'(ptr_q) + i) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_id  = IDW'((32'(ptr_q) + i) % NUM_REQ);
      end
    end
  end

  // Pointer moves just past the requester that was accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end
`else
  // Fixed priority: lowest pending index wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_valid[i]) begin
        grant_any = 1'b1;
        grant_id  = IDW'(i);
      end
    end
  end
`endif

  assign accept = (state_q == IDLE) && grant_any;

  // One-hot ready only while idle; held low throughout reset.
  always_comb begin
    req_ready = '0;
    if (accept && reset_n) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  bcd_dabble_step u_step (
    .word_in  (sr_q),
    .word_out (sr_step)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. CONVERT spends its final cycle (counter at BCD_ITER) only handing off,
  // so the response appears nine edges after the accepting edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_any) state_d = CONVERT;
      CONVERT: if (cnt_q == CNT_W'(BCD_ITER)) state_d = RESPOND;
      RESPOND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture on accept and one dabble iteration per CONVERT cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      id_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_any) begin
            sr_q  <= bcd_sr_t'(req_data[32'(grant_id)*BIN_W +: BIN_W]);
            id_q  <= grant_id;
            cnt_q <= '0;
          end
        end
        CONVERT: begin
          if (cnt_q != CNT_W'(BCD_ITER)) begin
            sr_q  <= sr_step;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid    = (state_q == RESPOND);
  assign busy         = (state_q != IDLE);
  assign rsp_id       = id_q;
  assign rsp_hundreds = sr_q[SR_W-1 -: DIGIT_W];
  assign rsp_tens     = sr_q[SR_W-1-DIGIT_W -: DIGIT_W];
  assign rsp_ones     = sr_q[SR_W-1-2*DIGIT_W -: DIGIT_W];

endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Self-checking bench for bcd_convert_scheduler against a behavioural arbitration/BCD model.
`timescale 1ns/1ps
module tb_bcd_convert_scheduler;

  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [8*NUM_REQ-1:0]   req_data;
  logic [NUM_REQ-1:0]     req_ready;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [3:0]             rsp_hundreds;
  logic [3:0]             rsp_tens;
  logic [3:0]             rsp_ones;
  logic                   busy;

  bcd_convert_scheduler #(.NUM_REQ(NUM_REQ), .IDW(IDW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_hundreds (rsp_hundreds),
    .rsp_tens     (rsp_tens),
    .rsp_ones     (rsp_ones),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: at most one request in flight.
  bit  inflight = 1'b0;
  int  in_id    = 0;
  int  in_val   = 0;
  int  acc_cyc  = 0;
  int  ptr      = 0;
  int  n_rsp    = 0;
  int  acc_log[$];
  logic [NUM_REQ-1:0] drop_mask = '1;
  bit  rand_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int i = 0; i < NUM_REQ; i++) begin
      int j = (p + i) % NUM_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 7))
      0:       return 8'd0;
      1:       return 8'd255;
      2:       return 8'd99;
      3:       return 8'd100;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic check_reset_outputs();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_hundreds", rsp_hundreds, 0);
    check_eq("rst_tens", rsp_tens, 0);
    check_eq("rst_ones", rsp_ones, 0);
  endtask

  // One clock: observe and check mid-cycle, then drive new inputs just after the edge.
  task automatic step();
    int pick;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] hs;
    bit exp_rv;
    bit acc_now;
    @(negedge clock);
    cyc++;
    pick      = inflight ? -1 : model_pick(req_valid, ptr);
    exp_ready = (pick < 0) ? '0 : (NUM_REQ'(1) << pick);
    check_eq("req_ready", req_ready, exp_ready);
    check_eq("ready_onehot", ($countones(req_ready) <= 1), 1);
    check_eq("busy", busy, inflight);
    exp_rv = inflight && (cyc - acc_cyc >= 10);
    check_eq("rsp_valid", rsp_valid, exp_rv);
    if (exp_rv) begin
      check_eq("rsp_id", rsp_id, in_id);
      check_eq("hundreds", rsp_hundreds, in_val / 100);
      check_eq("tens", rsp_tens, (in_val / 10) % 10);
      check_eq("ones", rsp_ones, in_val % 10);
    end
    hs = req_valid & req_ready;
    for (int k = 0; k < NUM_REQ; k++) if (hs[k]) acc_log.push_back(k);
    acc_now = 1'b0;
    if (exp_rv && rsp_ready) begin
      inflight = 1'b0;
      n_rsp++;
    end else if (pick >= 0) begin
      inflight = 1'b1;
      in_id    = pick;
      in_val   = int'(req_data[pick*8 +: 8]);
      acc_cyc  = cyc;
      acc_now  = 1'b1;
`ifdef BCD_SCHED_RR_EN
      ptr = (pick + 1) % NUM_REQ;
`endif
    end
    @(posedge clock);
    #1;
    if (acc_now && drop_mask[pick]) req_valid[pick] = 1'b0;
    if (rand_mode) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!req_valid[k]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[k]        = 1'b1;
            req_data[k*8 +: 8]  = rand_byte();
          end
        end else if ($urandom_range(0, 24) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (n_rsp < target && n < budget) begin
      step();
      n++;
    end
    if (n_rsp < target) check_eq("rsp_timeout", n_rsp, target);
  endtask

  task automatic run_single(input int k, input logic [7:0] v);
    req_data[k*8 +: 8] = v;
    req_valid[k]       = 1'b1;
    wait_rsp(n_rsp + 1, 60);
    step();
  endtask

  task automatic do_reset(input int hold);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    inflight = 1'b0;
    ptr      = 0;
    check_reset_outputs();
    repeat (hold) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((req_valid != '0 || inflight) && n < budget) begin
      step();
      n++;
    end
    if (req_valid != '0 || inflight) check_eq("drain_timeout", {req_valid, 3'b0, inflight}, 0);
  endtask

  initial begin
    int n;
    int start;
    reset_n   = 1'b0;
    req_valid = 4'b0110;
    req_data  = '0;
    rsp_ready = 1'b1;
    #2;
    check_reset_outputs();
    repeat (3) @(negedge clock);
    req_valid = '0;
    reset_n   = 1'b1;
    @(posedge clock);
    #1;
    repeat (3) step();

    // Directed values, including boundaries and a repeat.
    run_single(0, 8'd255);
    run_single(0, 8'd0);
    run_single(2, 8'd99);
    run_single(3, 8'd100);
    run_single(3, 8'd100);
    run_single(1, 8'd42);

    // All four pending, each dropping after its accept.
    start = acc_log.size();
    for (int k = 0; k < NUM_REQ; k++) req_data[k*8 +: 8] = rand_byte();
    req_valid = '1;
    drain(200);
    for (int i = 0; i < NUM_REQ; i++) check_eq("all4_order", acc_log[start + i], i);

    // Requester 0 held continuously while 1..3 also pend.
    drop_mask = 4'b1110;
    for (int k = 0; k < NUM_REQ; k++) req_data[k*8 +: 8] = rand_byte();
    req_valid = '1;
    start = acc_log.size();
    n = 0;
    while (acc_log.size() < start + 6 && n < 200) begin
      step();
      n++;
    end
    check_eq("held_accepts", acc_log.size() >= start + 6, 1);
`ifndef BCD_SCHED_RR_EN
    for (int i = 0; i < 3; i++) check_eq("held_fixed_order", acc_log[start + i], 0);
`endif
    req_valid[0] = 1'b0;
    drop_mask    = '1;
    drain(300);

    // Consumer stalls 20 cycles with another requester waiting.
    rsp_ready          = 1'b0;
    req_data[8 +: 8]   = rand_byte();
    req_valid[1]       = 1'b1;
    n = 0;
    while (!(inflight && cyc - acc_cyc >= 10) && n < 40) begin
      step();
      n++;
    end
    req_data[16 +: 8]  = rand_byte();
    req_valid[2]       = 1'b1;
    repeat (20) step();
    rsp_ready = 1'b1;
    wait_rsp(n_rsp + 1, 5);
    drain(100);

    // Reset on the 4th CONVERT cycle aborts the conversion.
    req_data[8 +: 8] = 8'd200;
    req_valid[1]     = 1'b1;
    n = 0;
    while (!inflight && n < 20) begin
      step();
      n++;
    end
    repeat (3) step();
    do_reset(2);
    repeat (30) step();
    run_single(2, 8'd42);
    check_eq("after_reset_tens", rsp_tens, 4);
    check_eq("after_reset_ones", rsp_ones, 2);

    // Randomized traffic with consumer back-pressure and request withdrawal.
    rand_mode = 1'b1;
    repeat (800) step();
    rand_mode = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
